// File: rtl/usb_fe_ctrl.sv
// USB full-speed frontend controller: rx synchroniser and glitch filter, line-state decode, attach sequencing,
// bus reset / suspend / resume detection and registered tx drive. Define USB_FE_SE1_DET_EN to build SE1 error detection.
module usb_fe_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 3,
    parameter int RESET_CYCLES   = 120,
    parameter int SUSPEND_CYCLES = 144000,
    parameter int ATTACH_CYCLES  = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fe_dp_rx,
    input  logic       fe_dn_rx,
    output logic       fe_dp_tx,
    output logic       fe_dn_tx,
    output logic       fe_tx_oen,
    output logic       fe_pu,
    input  logic       connect,
    input  logic       tx_valid,
    input  logic       tx_dp,
    input  logic       tx_dn,
    output logic [1:0] line_state,
    output logic       attached,
    output logic       bus_reset,
    output logic       suspend,
    output logic       resume,
    output logic       se1_err
);

    localparam int MAX_RS    = (RESET_CYCLES > SUSPEND_CYCLES) ? RESET_CYCLES : SUSPEND_CYCLES;
    localparam int MAX_CYC   = (MAX_RS > ATTACH_CYCLES) ? MAX_RS : ATTACH_CYCLES;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] RESET_MAX   = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] SUSPEND_MAX = CNT_W'(SUSPEND_CYCLES);
    localparam logic [CNT_W-1:0] ATTACH_LAST = CNT_W'(ATTACH_CYCLES - 1);

    localparam logic [1:0] ST_DETACHED    = 2'd0;
    localparam logic [1:0] ST_ATTACH_WAIT = 2'd1;
    localparam logic [1:0] ST_ATTACHED    = 2'd2;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;

    // Line codes are {dn, dp}, so J (dp=1) is 01 and K (dn=1) is 10.
    logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
    logic [FILTER_LEN-1:0][1:0]  filt_q, filt_d;
    logic [1:0]                  line_state_q, line_state_d;
    logic                        filt_stable;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] att_cnt_q, att_cnt_d;
    logic [CNT_W-1:0] se0_cnt_q, se0_cnt_d;
    logic [CNT_W-1:0] j_cnt_q, j_cnt_d;
    logic             bus_reset_q, bus_reset_d;
    logic             suspend_q, suspend_d;
    logic             resume_q, resume_d;
    logic             fe_tx_oen_q, fe_tx_oen_d;
    logic             fe_dp_tx_q, fe_dn_tx_q;
    logic             is_attached;

    assign is_attached = (state_q == ST_ATTACHED);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], fe_dn_rx, fe_dp_rx};

        filt_stable = 1'b1;
        for (int i = 1; i < FILTER_LEN; i++) begin
            if (filt_q[i] != filt_q[0]) filt_stable = 1'b0;
        end

        // Own transmissions are not received: filter and line state freeze while driving.
        filt_d       = filt_q;
        line_state_d = line_state_q;
        if (!fe_tx_oen_q) begin
            filt_d[0] = sync_q[SYNC_STAGES-1];
            for (int i = 1; i < FILTER_LEN; i++) filt_d[i] = filt_q[i-1];
            if (filt_stable && (filt_q[0] != line_state_q)) line_state_d = filt_q[0];
        end
    end

    always_comb begin
        state_d     = state_q;
        att_cnt_d   = att_cnt_q;
        se0_cnt_d   = '0;
        j_cnt_d     = '0;
        bus_reset_d = 1'b0;
        suspend_d   = 1'b0;
        resume_d    = 1'b0;
        fe_tx_oen_d = tx_valid & is_attached;

        if (!connect) begin
            state_d   = ST_DETACHED;
            att_cnt_d = '0;
        end else begin
            case (state_q)
                ST_DETACHED: begin
                    state_d   = ST_ATTACH_WAIT;
                    att_cnt_d = '0;
                end
                ST_ATTACH_WAIT: begin
                    if (att_cnt_q == ATTACH_LAST) state_d = ST_ATTACHED;
                    else att_cnt_d = att_cnt_q + 1'b1;
                end
                ST_ATTACHED: begin
                    if (fe_tx_oen_q) begin
                        bus_reset_d = bus_reset_q;
                        suspend_d   = suspend_q;
                    end else begin
                        if (line_state_q == LS_SE0)
                            se0_cnt_d = (se0_cnt_q == RESET_MAX) ? se0_cnt_q : se0_cnt_q + 1'b1;
                        if (line_state_q == LS_J)
                            j_cnt_d = (j_cnt_q == SUSPEND_MAX) ? j_cnt_q : j_cnt_q + 1'b1;
                        bus_reset_d = (line_state_q == LS_SE0) && (bus_reset_q || (se0_cnt_d == RESET_MAX));
                        suspend_d   = (line_state_q == LS_J) && (suspend_q || (j_cnt_d == SUSPEND_MAX));
                        resume_d    = suspend_q && (line_state_q == LS_K);
                        // A bus reset ends suspend silently.
                        if (bus_reset_d && !bus_reset_q) begin
                            suspend_d = 1'b0;
                            resume_d  = 1'b0;
                        end
                    end
                end
                default: state_d = ST_DETACHED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            filt_q       <= '0;
            line_state_q <= LS_SE0;
            state_q      <= ST_DETACHED;
            att_cnt_q    <= '0;
            se0_cnt_q    <= '0;
            j_cnt_q      <= '0;
            bus_reset_q  <= 1'b0;
            suspend_q    <= 1'b0;
            resume_q     <= 1'b0;
            fe_tx_oen_q  <= 1'b0;
            fe_dp_tx_q   <= 1'b0;
            fe_dn_tx_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            filt_q       <= filt_d;
            line_state_q <= line_state_d;
            state_q      <= state_d;
            att_cnt_q    <= att_cnt_d;
            se0_cnt_q    <= se0_cnt_d;
            j_cnt_q      <= j_cnt_d;
            bus_reset_q  <= bus_reset_d;
            suspend_q    <= suspend_d;
            resume_q     <= resume_d;
            fe_tx_oen_q  <= fe_tx_oen_d;
            fe_dp_tx_q   <= tx_dp;
            fe_dn_tx_q   <= tx_dn;
        end
    end

`ifdef USB_FE_SE1_DET_EN
    localparam logic [1:0] LS_SE1 = 2'b11;
    logic se1_err_q, se1_err_d;

    // Pulse on the clock line_state enters SE1, so it coincides with the new state.
    always_comb se1_err_d = is_attached && (line_state_d == LS_SE1) && (line_state_q != LS_SE1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) se1_err_q <= 1'b0;
        else     se1_err_q <= se1_err_d;
    end

    assign se1_err = se1_err_q;
`else
    assign se1_err = 1'b0;
`endif

    assign fe_dp_tx   = fe_dp_tx_q;
    assign fe_dn_tx   = fe_dn_tx_q;
    assign fe_tx_oen  = fe_tx_oen_q;
    assign fe_pu      = is_attached;
    assign attached   = is_attached;
    assign line_state = line_state_q;
    assign bus_reset  = bus_reset_q;
    assign suspend    = suspend_q;
    assign resume     = resume_q;

endmodule

// File: tb/tb_usb_fe_ctrl.sv
// Randomised self-checking bench for usb_fe_ctrl against a run-length behavioural model of the line and bus rules.
// SE1 expectations follow USB_FE_SE1_DET_EN as seen by this compile.
module tb_usb_fe_ctrl;

    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 3;
    localparam int RESET_CYCLES   = 120;
    localparam int SUSPEND_CYCLES = 1000;
    localparam int ATTACH_CYCLES  = 480;

    logic       clk = 1'b0;
    logic       rst;
    logic       fe_dp_rx, fe_dn_rx;
    logic       fe_dp_tx, fe_dn_tx, fe_tx_oen, fe_pu;
    logic       connect, tx_valid, tx_dp, tx_dn;
    logic [1:0] line_state;
    logic       attached, bus_reset, suspend, resume, se1_err;

    int total;
    int bad;

    usb_fe_ctrl #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .RESET_CYCLES  (RESET_CYCLES),
        .SUSPEND_CYCLES(SUSPEND_CYCLES),
        .ATTACH_CYCLES (ATTACH_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fe_dp_rx  (fe_dp_rx),
        .fe_dn_rx  (fe_dn_rx),
        .fe_dp_tx  (fe_dp_tx),
        .fe_dn_tx  (fe_dn_tx),
        .fe_tx_oen (fe_tx_oen),
        .fe_pu     (fe_pu),
        .connect   (connect),
        .tx_valid  (tx_valid),
        .tx_dp     (tx_dp),
        .tx_dn     (tx_dn),
        .line_state(line_state),
        .attached  (attached),
        .bus_reset (bus_reset),
        .suspend   (suspend),
        .resume    (resume),
        .se1_err   (se1_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [1:0] pin_dly[$];
    logic [1:0] m_ls, run_val;
    int         run_len, conn_run, se0_run, j_run;
    logic       m_att, m_oen, m_dp, m_dn, m_br, m_sus, m_res, m_se1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        pin_dly.delete();
        for (int i = 0; i < SYNC_STAGES; i++) pin_dly.push_back(2'b00);
        m_ls = 2'b00; run_val = 2'b00; run_len = FILTER_LEN;
        conn_run = 0; se0_run = 0; j_run = 0;
        m_att = 0; m_oen = 0; m_dp = 0; m_dn = 0;
        m_br = 0; m_sus = 0; m_res = 0; m_se1 = 0;
    endtask

    // Advance the model by one clock using the inputs presented for this edge.
    task automatic model_edge();
        logic [1:0] pre_ls, new_ls, fin;
        logic       pre_att, pre_oen, old_br, old_sus;
        pre_ls = m_ls; pre_att = m_att; pre_oen = m_oen;

        new_ls = m_ls;
        fin = pin_dly.pop_front();
        pin_dly.push_back({fe_dn_rx, fe_dp_rx});
        if (!pre_oen) begin
            if (run_len >= FILTER_LEN && run_val != m_ls) new_ls = run_val;
            if (fin == run_val) begin
                if (run_len < FILTER_LEN) run_len++;
            end else begin
                run_val = fin;
                run_len = 1;
            end
        end

        conn_run = connect ? ((conn_run > ATTACH_CYCLES) ? conn_run : conn_run + 1) : 0;
        m_att = (conn_run >= ATTACH_CYCLES + 1);

        m_oen = tx_valid & pre_att;
        m_dp = tx_dp;
        m_dn = tx_dn;

        if (!(pre_att && connect)) begin
            m_br = 0; m_sus = 0; m_res = 0; se0_run = 0; j_run = 0;
        end else if (pre_oen) begin
            m_res = 0; se0_run = 0; j_run = 0;
        end else begin
            old_br = m_br; old_sus = m_sus;
            se0_run = (pre_ls == 2'b00) ? se0_run + 1 : 0;
            j_run   = (pre_ls == 2'b01) ? j_run + 1 : 0;
            m_br  = (pre_ls == 2'b00) && (old_br || se0_run >= RESET_CYCLES);
            m_sus = (pre_ls == 2'b01) && (old_sus || j_run >= SUSPEND_CYCLES);
            m_res = old_sus && (pre_ls == 2'b10);
            if (m_br && !old_br) begin m_sus = 0; m_res = 0; end
        end

`ifdef USB_FE_SE1_DET_EN
        m_se1 = pre_att && (new_ls == 2'b11) && (pre_ls != 2'b11);
`else
        m_se1 = 1'b0;
`endif
        m_ls = new_ls;
    endtask

    task automatic compare_all();
        check("line_state", line_state, m_ls);
        check("attached", attached, m_att);
        check("fe_pu", fe_pu, m_att);
        check("fe_tx_oen", fe_tx_oen, m_oen);
        check("fe_dp_tx", fe_dp_tx, m_dp);
        check("fe_dn_tx", fe_dn_tx, m_dn);
        check("bus_reset", bus_reset, m_br);
        check("suspend", suspend, m_sus);
        check("resume", resume, m_res);
        check("se1_err", se1_err, m_se1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic seg(input logic [1:0] p, input int len, input logic txv, input logic c);
        for (int i = 0; i < len; i++) begin
            fe_dp_rx = p[0];
            fe_dn_rx = p[1];
            tx_valid = txv;
            connect  = c;
            tx_dp    = 1'($urandom_range(0, 1));
            tx_dn    = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    initial begin
        int r, len;
        logic [1:0] p;
        logic txv, c;
        total = 0;
        bad = 0;
        rst = 1'b1;
        fe_dp_rx = 1'b1; fe_dn_rx = 1'b0;
        connect = 1'b0; tx_valid = 1'b0; tx_dp = 1'b0; tx_dn = 1'b0;
        model_reset();
        #22;
        compare_all();
        rst = 1'b0;

        seg(2'b01, 8, 1'b1, 1'b0);      // tx while detached
        seg(2'b01, 490, 1'b0, 1'b1);    // attach
        seg(2'b10, 2, 1'b0, 1'b1);      // short glitch
        seg(2'b01, 10, 1'b0, 1'b1);
        seg(2'b10, 3, 1'b0, 1'b1);      // minimum accepted K
        seg(2'b01, 10, 1'b0, 1'b1);
        seg(2'b00, 119, 1'b0, 1'b1);    // just short of a bus reset
        seg(2'b01, 10, 1'b0, 1'b1);
        seg(2'b00, 130, 1'b0, 1'b1);    // bus reset
        seg(2'b01, 1010, 1'b0, 1'b1);   // suspend
        seg(2'b10, 5, 1'b0, 1'b1);      // resume via K
        seg(2'b01, 1010, 1'b0, 1'b1);
        seg(2'b00, 5, 1'b0, 1'b1);      // leave suspend via SE0
        seg(2'b01, 20, 1'b0, 1'b1);
        seg(2'b01, 8, 1'b1, 1'b1);      // transmit burst
        seg(2'b10, 12, 1'b0, 1'b1);
        seg(2'b11, 4, 1'b0, 1'b1);      // SE1
        seg(2'b01, 10, 1'b0, 1'b1);
        seg(2'b01, 3, 1'b0, 1'b0);      // detach
        seg(2'b01, 490, 1'b0, 1'b1);

        for (int s = 0; s < 60; s++) begin
            r = int'($urandom_range(0, 99));
            txv = 1'b0;
            c = 1'b1;
            if (r < 12) begin
                p = 2'b01; len = int'($urandom_range(995, 1010));
            end else if (r < 24) begin
                p = 2'b00; len = int'($urandom_range(115, 125));
            end else if (r < 34) begin
                p = 2'($urandom_range(0, 3)); len = int'($urandom_range(2, 12)); txv = 1'b1;
            end else if (r < 38) begin
                p = 2'b01; len = int'($urandom_range(1, 5)); c = 1'b0;
            end else begin
                p = 2'($urandom_range(0, 3)); len = int'($urandom_range(1, 6));
            end
            seg(p, len, txv, c);
        end

        // Asynchronous reset in the middle of a transmission.
        seg(2'b01, 490, 1'b0, 1'b1);
        seg(2'b01, 3, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_oen", fe_tx_oen, 1'b0);
        check("async_rst_pu", fe_pu, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_valid = 1'b0;
        model_reset();
        compare_all();
        seg(2'b01, 30, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_fe_ctrl.md
Name: usb_fe_ctrl

Overview:
Parametrised controller for the USB full-speed "analog" frontend. It synchronises and glitch-filters D+/D- receive inputs and decodes the bus line state. It detects bus reset, suspend and resume, sequences pull-up attach, and registers the transmit drive and output enable. It sits between the frontend pins (dp_rx/dn_rx/dp_tx/dn_tx/tx_oen/pu) and the SIE's NRZI decoder and encoder.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on dp/dn rx; minimum 2.
FILTER_LEN, 3, number of consecutive identical synchronised samples required before line_state updates; minimum 1.
RESET_CYCLES, 120, continuous SE0 clocks that constitute a bus reset (2.5 us at 48 MHz).
SUSPEND_CYCLES, 144000, continuous J clocks that constitute suspend (3 ms at 48 MHz).
ATTACH_CYCLES, 480, clocks that connect must stay high before the pull-up is enabled.
(localparam) CNT_W, $clog2(max(RESET_CYCLES,SUSPEND_CYCLES,ATTACH_CYCLES)+1), width of the shared counters.

Ports:
clk  input  1  system clock (48 MHz)
rst  input  1  asynchronous reset, active-high
fe_dp_rx  input  1  raw D+ from frontend
fe_dn_rx  input  1  raw D- from frontend
fe_dp_tx  output  1  registered D+ drive
fe_dn_tx  output  1  registered D- drive
fe_tx_oen  output  1  registered drive enable
fe_pu  output  1  D+ pull-up control
connect  input  1  request to attach (VBUS present / software connect)
tx_valid  input  1  encoder is driving this cycle
tx_dp  input  1  encoder D+ value
tx_dn  input  1  encoder D- value
line_state  output  2  filtered state: 00 SE0, 01 J, 10 K, 11 SE1
attached  output  1  pull-up active
bus_reset  output  1  high while a qualified bus reset is in progress
suspend  output  1  high while the bus is suspended
resume  output  1  one-cycle pulse on K while suspended
se1_err  output  1  SE1 error pulse (see Optional Feature)

Behaviour:
- One clock domain. clk and rst are the only clock and reset: one clock, with an asynchronous, active-high reset.
- Reset values: all outputs 0; line_state=00; attach FSM in DETACHED; counters and filter registers 0.
- Receive path: {dp,dn} goes through a SYNC_STAGES flop chain, then a FILTER_LEN shift register. When all FILTER_LEN entries are equal and differ from line_state, line_state takes that value on the next clock. Pin-to-line_state latency is SYNC_STAGES+FILTER_LEN+1 clocks. A glitch shorter than FILTER_LEN clocks never reaches line_state.
- Encoding: dp=1,dn=0 is J (01); dp=0,dn=1 is K (10); both 0 is SE0 (00); both 1 is SE1 (11).
- Attach FSM:
  - DETACHED: fe_pu=0. connect=1 moves to ATTACH_WAIT and clears the counter.
  - ATTACH_WAIT: the counter increments each clock. Reaching ATTACH_CYCLES-1 moves to ATTACHED.
  - ATTACHED: fe_pu=1, attached=1.
  - connect=0 in any state returns to DETACHED on the next clock and clears bus_reset, suspend and all counters.
- Transmit path: fe_tx_oen <= tx_valid & attached; fe_dp_tx <= tx_dp; fe_dn_tx <= tx_dn. Latency is 1 clock. tx_valid is ignored when not attached (fe_tx_oen stays 0).
- While fe_tx_oen=1: the filter input is ignored, line_state holds, and the reset and suspend counters are held at 0. Filtering resumes the first clock after fe_tx_oen falls.
- Reset and suspend detection (ATTACHED only):
  - SE0 counter: increments while line_state=00 and saturates; cleared when line_state≠00.
  - bus_reset sets when the SE0 counter reaches RESET_CYCLES and clears the clock after line_state leaves 00.
  - J counter: increments while line_state=01 and saturates; cleared otherwise.
  - suspend sets when the J counter reaches SUSPEND_CYCLES.
  - suspend clears when line_state≠01. If the new state is K (10), resume pulses high for exactly 1 clock on the same clock that suspend clears.
  - bus_reset setting also clears suspend, with no resume pulse.
- Saturating counters never wrap.
- rst mid-transfer: fe_tx_oen drops immediately (asynchronously) and fe_pu drops immediately.

Optional Feature:
Macro USB_FE_SE1_DET_EN.
- Defined: se1_err pulses high for 1 clock each time line_state transitions into 11 while attached. An SE1 state also clears the J and SE0 counters.
- Undefined: se1_err is tied to 0, no SE1 logic is built, and SE1 is treated as "not J / not SE0" for the counters only.

Test Plan:
- Attach: rst low, connect=1 held → fe_pu and attached rise exactly 480 clocks after connect is sampled. connect=0 → fe_pu=0 next clock.
- Glitch filter: idle J, then a 2-clock K pulse on the pins → line_state stays 01. A 3-clock K pulse → line_state=10 six clocks (2+3+1) after the first K edge.
- Bus reset: attached, drive SE0 for 119 clocks → bus_reset=0. Drive SE0 for 130 clocks → bus_reset=1 from the 120th SE0 line_state clock, then 0 one clock after J returns.
- Suspend/resume (override SUSPEND_CYCLES=1000): J held → suspend=1 after 1000 J clocks. Then K → suspend=0 and a single-clock resume pulse. Repeat with SE0 instead of K → suspend clears and resume stays 0.
- Transmit: attached, tx_valid=1 with tx_dp/tx_dn=1/0 for 8 clocks → fe_tx_oen high 8 clocks delayed by 1. line_state is frozen and the suspend counter is 0 on release. tx_valid while detached → fe_tx_oen=0.
- SE1 (macro defined): drive dp=dn=1 for 4 clocks → one se1_err pulse. Macro undefined → se1_err=0 throughout.
